// File: rtl/pll_supervisor.sv
// pll_supervisor: sequences the PLL reset and qualifies its lock flag.
// It releases downstream logic only after the synchronised lock has stayed
// high for a full stability window. It re-resets the PLL when lock takes too
// long to appear, and goes back to waiting for lock when lock is lost in RUN.
// Lock timeouts and lock losses are counted for debug.
module pll_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clock_in,
  input  logic       resetb,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_resetb,
  output logic       ready,
  output logic [3:0] timeout_count,
  output logic [3:0] loss_count
);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating 4-bit event counter step; holds at 15.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic en);
    logic [3:0] r;
    if (en && (v != 4'd15)) begin
      r = v + 4'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             lock_s;
  logic             timeout_ev_d, loss_ev_d;
  logic [3:0]       timeout_count_q, loss_count_q;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_resetb_q, sys_resetb_d;
  logic             ready_q, ready_d;

  // Two-flop synchroniser bringing the asynchronous lock flag into clock_in.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked;
      sync2_q <= sync1_q;
    end
  end

  assign lock_s = sync2_q;

  // State register and the shared phase counter.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter restarts from zero on every state change,
  // and a restart request overrides everything, including event counting.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_ev_d = 1'b0;
    loss_ev_d    = 1'b0;
    if (restart) begin
      state_d = ST_PLL_RST;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d      = ST_PLL_RST;
            cnt_d        = CNT_ZERO;
            timeout_ev_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          // Lock loss goes back to waiting; the PLL itself is left running.
          if (!lock_s) begin
            state_d   = ST_WAIT_LOCK;
            loss_ev_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
          cnt_d = CNT_ZERO;
        end
        default: begin
          state_d = ST_PLL_RST;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs move with the transition.
  always_comb begin
    pll_resetb_d = (state_d != ST_PLL_RST);
    sys_resetb_d = (state_d == ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  // Registered outputs.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      pll_resetb_q <= 1'b0;
      sys_resetb_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      pll_resetb_q <= pll_resetb_d;
      sys_resetb_q <= sys_resetb_d;
      ready_q      <= ready_d;
    end
  end

  // Debug event counters; cleared only by the asynchronous reset.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      timeout_count_q <= 4'd0;
      loss_count_q    <= 4'd0;
    end else begin
      timeout_count_q <= sat_inc4(timeout_count_q, timeout_ev_d);
      loss_count_q    <= sat_inc4(loss_count_q, loss_ev_d);
    end
  end

  assign pll_resetb    = pll_resetb_q;
  assign sys_resetb    = sys_resetb_q;
  assign ready         = ready_q;
  assign timeout_count = timeout_count_q;
  assign loss_count    = loss_count_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Testbench for pll_supervisor: directed test-plan steps plus a randomized
// phase, all checked against a behavioural model of the sequencing rules.
module tb_pll_supervisor;

  localparam int RST_C = 4;
  localparam int TO_C  = 32;
  localparam int STB_C = 8;

  logic       clock_in;
  logic       resetb;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_resetb;
  logic       ready;
  logic [3:0] timeout_count;
  logic [3:0] loss_count;

  int n_cmp;
  int n_bad;
  int ecount;

  // Behavioural model: phase name, cycles spent in it, lock delay line, events
  string m_phase;
  int    m_age;
  int    m_dly0, m_dly1;
  int    m_tc, m_lc;

  pll_supervisor #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TO_C),
    .STABLE_CYCLES(STB_C),
    .CNT_W        (6)
  ) dut (
    .clock_in     (clock_in),
    .resetb       (resetb),
    .locked       (locked),
    .restart      (restart),
    .pll_resetb   (pll_resetb),
    .sys_resetb   (sys_resetb),
    .ready        (ready),
    .timeout_count(timeout_count),
    .loss_count   (loss_count)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, ecount, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_phase = "PLL_RST";
    m_age   = 0;
    m_dly0  = 0;
    m_dly1  = 0;
    m_tc    = 0;
    m_lc    = 0;
    ecount  = 0;
  endtask

  // One clock edge of the model, driven by the inputs present at that edge.
  task automatic mdl_edge();
    int seen;
    seen = m_dly1;
    m_dly1 = m_dly0;
    m_dly0 = (locked === 1'b1) ? 1 : 0;
    if (restart === 1'b1) begin
      m_phase = "PLL_RST";
      m_age   = 0;
    end else if (m_phase == "PLL_RST") begin
      m_age++;
      if (m_age >= RST_C) begin
        m_phase = "WAIT_LOCK";
        m_age   = 0;
      end
    end else if (m_phase == "WAIT_LOCK") begin
      if (seen == 1) begin
        m_phase = "STABLE";
        m_age   = 0;
      end else if (m_age + 1 >= TO_C) begin
        m_phase = "PLL_RST";
        m_age   = 0;
        m_tc    = (m_tc < 15) ? m_tc + 1 : 15;
      end else begin
        m_age++;
      end
    end else if (m_phase == "STABLE") begin
      if (seen == 0) begin
        m_phase = "WAIT_LOCK";
        m_age   = 0;
      end else if (m_age + 1 >= STB_C) begin
        m_phase = "RUN";
        m_age   = 0;
      end else begin
        m_age++;
      end
    end else begin
      if (seen == 0) begin
        m_phase = "WAIT_LOCK";
        m_age   = 0;
        m_lc    = (m_lc < 15) ? m_lc + 1 : 15;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    mdl_edge();
    ecount++;
    #1;
    check("pll_resetb", {3'd0, pll_resetb}, (m_phase != "PLL_RST") ? 4'd1 : 4'd0);
    check("sys_resetb", {3'd0, sys_resetb}, (m_phase == "RUN") ? 4'd1 : 4'd0);
    check("ready", {3'd0, ready}, (m_phase == "RUN") ? 4'd1 : 4'd0);
    check("timeout_count", timeout_count, 4'(m_tc));
    check("loss_count", loss_count, 4'(m_lc));
  endtask

  task automatic run_to(input int n);
    while (ecount < n) tick();
  endtask

  // Assert reset just after an edge, release it on the following falling edge.
  task automatic do_reset(input logic lk);
    #2;
    resetb = 1'b0;
    @(negedge clock_in);
    locked  = lk;
    restart = 1'b0;
    mdl_reset();
    resetb = 1'b1;
  endtask

  initial begin
    int hold;
    n_cmp   = 0;
    n_bad   = 0;
    resetb  = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
    mdl_reset();
    #3;
    check("rst_pll_resetb", {3'd0, pll_resetb}, 4'd0);
    check("rst_sys_resetb", {3'd0, sys_resetb}, 4'd0);
    check("rst_ready", {3'd0, ready}, 4'd0);
    check("rst_timeout", timeout_count, 4'd0);
    check("rst_loss", loss_count, 4'd0);

    // Test 1: lock tied high from reset release
    @(negedge clock_in);
    locked = 1'b1;
    resetb = 1'b1;
    run_to(3);
    check("t1_pll_low_e3", {3'd0, pll_resetb}, 4'd0);
    tick();
    check("t1_pll_high_e4", {3'd0, pll_resetb}, 4'd1);
    run_to(12);
    check("t1_ready_e12", {3'd0, ready}, 4'd0);
    tick();
    check("t1_ready_e13", {3'd0, ready}, 4'd1);
    check("t1_sysrst_e13", {3'd0, sys_resetb}, 4'd1);
    check("t1_counters", {timeout_count[1:0], loss_count[1:0]}, 4'd0);

    // Test 2: lock tied low, timeouts repeat and saturate
    do_reset(1'b0);
    run_to(35);
    check("t2_pll_high_e35", {3'd0, pll_resetb}, 4'd1);
    check("t2_tc0", timeout_count, 4'd0);
    tick();
    check("t2_pll_low_e36", {3'd0, pll_resetb}, 4'd0);
    check("t2_tc1", timeout_count, 4'd1);
    run_to(2 * (RST_C + TO_C));
    check("t2_tc2", timeout_count, 4'd2);
    run_to(15 * (RST_C + TO_C));
    check("t2_tc15", timeout_count, 4'd15);
    run_to(17 * (RST_C + TO_C));
    check("t2_tc_sat", timeout_count, 4'd15);

    // Test 3: one-cycle lock glitch during STABLE
    do_reset(1'b1);
    run_to(7);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    run_to(18);
    check("t3_ready_e18", {3'd0, ready}, 4'd0);
    tick();
    check("t3_ready_e19", {3'd0, ready}, 4'd1);
    check("t3_counters", {timeout_count[1:0], loss_count[1:0]}, 4'd0);

    // Test 4: lock loss in RUN and recovery
    run_to(25);
    locked = 1'b0;
    run_to(27);
    check("t4_ready_e27", {3'd0, ready}, 4'd1);
    tick();
    check("t4_ready_e28", {3'd0, ready}, 4'd0);
    check("t4_sysrst_e28", {3'd0, sys_resetb}, 4'd0);
    check("t4_loss1", loss_count, 4'd1);
    check("t4_pll_stays", {3'd0, pll_resetb}, 4'd1);
    run_to(30);
    locked = 1'b1;
    run_to(40);
    check("t4_ready_e40", {3'd0, ready}, 4'd0);
    tick();
    check("t4_ready_e41", {3'd0, ready}, 4'd1);

    // Test 5: restart coincides with lock loss
    run_to(45);
    locked = 1'b0;
    run_to(47);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("t5_pll_low_e48", {3'd0, pll_resetb}, 4'd0);
    check("t5_loss_kept", loss_count, 4'd1);
    run_to(51);
    check("t5_pll_low_e51", {3'd0, pll_resetb}, 4'd0);
    tick();
    check("t5_pll_high_e52", {3'd0, pll_resetb}, 4'd1);

    // Test 6: asynchronous reset in the middle of STABLE
    locked = 1'b1;
    run_to(57);
    #2;
    resetb = 1'b0;
    #1;
    check("t6_pll_resetb", {3'd0, pll_resetb}, 4'd0);
    check("t6_sys_resetb", {3'd0, sys_resetb}, 4'd0);
    check("t6_ready", {3'd0, ready}, 4'd0);
    check("t6_timeout", timeout_count, 4'd0);
    check("t6_loss", loss_count, 4'd0);
    @(negedge clock_in);
    mdl_reset();
    resetb = 1'b1;

    // Randomized phase: lock flapping with occasional restart requests
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin
        locked = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
        hold   = (locked == 1'b1) ? $urandom_range(1, 40) : $urandom_range(1, 12);
      end
      hold--;
      restart = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      tick();
    end
    restart = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
